// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Brief    : Two-requester round-robin arbiter in front of a single-port RAM
//            with combinational read. m0 is the processor, m1 the DMA port.
//            m1 may hold a locked burst of up to MAX_BURST beats. Read data
//            is registered back to the winning requester one cycle later.
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
    parameter int MEMORY_BUS_WIDTH = 32,
    parameter int ADDR_WIDTH       = 32,
    parameter int MAX_BURST        = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        m0_req,
    input  logic [ADDR_WIDTH-1:0]       m0_addr,
    input  logic [MEMORY_BUS_WIDTH-1:0] m0_wdata,
    input  logic [3:0]                  m0_wb,
    output logic                        m0_gnt,
    output logic [MEMORY_BUS_WIDTH-1:0] m0_rdata,
    output logic                        m0_rvalid,
    input  logic                        m1_req,
    input  logic [ADDR_WIDTH-1:0]       m1_addr,
    input  logic [MEMORY_BUS_WIDTH-1:0] m1_wdata,
    input  logic [3:0]                  m1_wb,
    input  logic                        m1_lock,
    output logic                        m1_gnt,
    output logic [MEMORY_BUS_WIDTH-1:0] m1_rdata,
    output logic                        m1_rvalid,
    output logic                        mem_enable_out,
    output logic [ADDR_WIDTH-1:0]       mem_addr_out,
    output logic [MEMORY_BUS_WIDTH-1:0] mem_data_out,
    output logic [3:0]                  mem_wb_out,
    input  logic [MEMORY_BUS_WIDTH-1:0] mem_data_in
);

    localparam int c_CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [0:0] c_ST_ARB   = 1'b0;
    localparam logic [0:0] c_ST_BURST = 1'b1;

    localparam logic c_M0 = 1'b0;
    localparam logic c_M1 = 1'b1;

    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(MAX_BURST);

    logic [0:0]                  r_state;
    logic                        r_last;
    logic [c_CNT_W-1:0]          r_cnt;
    logic [MEMORY_BUS_WIDTH-1:0] r_m0_rdata;
    logic [MEMORY_BUS_WIDTH-1:0] r_m1_rdata;
    logic                        r_m0_rvalid;
    logic                        r_m1_rvalid;

    logic                        w_gnt0;
    logic                        w_gnt1;
    logic                        w_final_beat;

    // The beat granted now is the MAX_BURST-th one of the burst
    assign w_final_beat = ((r_cnt + c_CNT_ONE) >= c_CNT_MAX);

    // Grant decision: burst keeps m1 while it holds req+lock, otherwise round-robin
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!reset) begin
            if (r_state == c_ST_BURST) begin
                w_gnt1 = m1_req & m1_lock;
            end else if (m0_req && m1_req) begin
                w_gnt0 = (r_last == c_M1);
                w_gnt1 = (r_last == c_M0);
            end else begin
                w_gnt0 = m0_req;
                w_gnt1 = m1_req;
            end
        end
    end

    // RAM port mux: winner's fields pass straight through, all zero when idle
    always_comb begin
        mem_enable_out = 1'b0;
        mem_addr_out   = '0;
        mem_data_out   = '0;
        mem_wb_out     = 4'b0000;
        if (w_gnt0) begin
            mem_enable_out = 1'b1;
            mem_addr_out   = m0_addr;
            mem_data_out   = m0_wdata;
            mem_wb_out     = m0_wb;
        end else if (w_gnt1) begin
            mem_enable_out = 1'b1;
            mem_addr_out   = m1_addr;
            mem_data_out   = m1_wdata;
            mem_wb_out     = m1_wb;
        end
    end

    // Arbitration state: last winner, burst entry/exit and saturating beat count
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_ST_ARB;
            r_last  <= c_M1;
            r_cnt   <= '0;
        end else if (r_state == c_ST_ARB) begin
            if (w_gnt0) begin
                r_last <= c_M0;
            end else if (w_gnt1) begin
                r_last <= c_M1;
                if (m1_lock) begin
                    r_state <= c_ST_BURST;
                    r_cnt   <= c_CNT_ONE;
                end
            end
        end else begin
            // m1 is recorded as last on exit so m0 wins the next contest
            r_last <= c_M1;
            if (w_gnt1) begin
                if (r_cnt != c_CNT_MAX) begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                end
                if (w_final_beat) begin
                    r_state <= c_ST_ARB;
                end
            end else begin
                r_state <= c_ST_ARB;
            end
        end
    end

    // Read return: capture RAM data for the read winner, one-cycle valid pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            r_m0_rdata  <= '0;
            r_m1_rdata  <= '0;
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
        end else begin
            r_m0_rvalid <= w_gnt0 && (m0_wb == 4'b0000);
            r_m1_rvalid <= w_gnt1 && (m1_wb == 4'b0000);
            if (w_gnt0 && (m0_wb == 4'b0000)) begin
                r_m0_rdata <= mem_data_in;
            end
            if (w_gnt1 && (m1_wb == 4'b0000)) begin
                r_m1_rdata <= mem_data_in;
            end
        end
    end

    assign m0_gnt    = w_gnt0;
    assign m1_gnt    = w_gnt1;
    assign m0_rdata  = r_m0_rdata;
    assign m1_rdata  = r_m1_rdata;
    assign m0_rvalid = r_m0_rvalid;
    assign m1_rvalid = r_m1_rvalid;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arbiter
// Brief    : Self-checking bench for ram_arbiter (MAX_BURST = 4) with a RAM
//            model, a behavioural arbitration/memory reference and random
//            traffic after the directed steps.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

    localparam int MB = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        m0_req, m1_req, m1_lock;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_wb, m1_wb;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_enable_out;
    logic [31:0] mem_addr_out, mem_data_out, mem_data_in;
    logic [3:0]  mem_wb_out;

    logic [31:0] ram [256];
    logic [31:0] mm  [256];

    int          checks = 0;
    int          errors = 0;

    // Reference state: last winner, beats granted in current burst (0 = none)
    int          m_last;
    int          m_beats;
    int          m_w;
    logic [31:0] e_rd0, e_rd1;
    logic        e_rv0, e_rv1;

    bit          pend0, pend1;

    ram_arbiter #(
        .MEMORY_BUS_WIDTH(32),
        .ADDR_WIDTH(32),
        .MAX_BURST(MB)
    ) dut (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wb(m0_wb),
        .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wb(m1_wb),
        .m1_lock(m1_lock),
        .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
        .mem_enable_out(mem_enable_out), .mem_addr_out(mem_addr_out),
        .mem_data_out(mem_data_out), .mem_wb_out(mem_wb_out),
        .mem_data_in(mem_data_in)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] b);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) r[8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    // RAM: combinational read, byte-strobed write at the rising edge
    assign mem_data_in = ram[mem_addr_out[9:2]];
    always @(posedge clock) begin
        if (mem_enable_out && (mem_wb_out != 4'd0)) begin
            ram[mem_addr_out[9:2]] <= merge(ram[mem_addr_out[9:2]], mem_data_out, mem_wb_out);
        end
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs already driven after a falling edge
    task automatic cycle();
        int          w;
        logic [31:0] a, d;
        logic [3:0]  b;
        #1;
        w = -1;
        if (!reset) begin
            if (m_beats > 0) begin
                if (m1_req && m1_lock) w = 1;
            end else if (m0_req && m1_req) begin
                w = (m_last == 1) ? 0 : 1;
            end else if (m0_req) begin
                w = 0;
            end else if (m1_req) begin
                w = 1;
            end
        end
        a = (w == 0) ? m0_addr  : (w == 1) ? m1_addr  : 32'd0;
        d = (w == 0) ? m0_wdata : (w == 1) ? m1_wdata : 32'd0;
        b = (w == 0) ? m0_wb    : (w == 1) ? m1_wb    : 4'd0;
        m_w = w;
        chk("m0_gnt",  {31'd0, m0_gnt},         {31'd0, w == 0});
        chk("m1_gnt",  {31'd0, m1_gnt},         {31'd0, w == 1});
        chk("mem_en",  {31'd0, mem_enable_out}, {31'd0, w >= 0});
        chk("mem_addr", mem_addr_out, a);
        chk("mem_data", mem_data_out, d);
        chk("mem_wb",  {28'd0, mem_wb_out},     {28'd0, b});
        @(posedge clock);
        e_rv0 = 1'b0;
        e_rv1 = 1'b0;
        if (reset) begin
            m_last  = 1;
            m_beats = 0;
            e_rd0   = 32'd0;
            e_rd1   = 32'd0;
        end else begin
            if (m_beats > 0) begin
                if (w == 1) begin
                    m_beats++;
                    if (m_beats == MB) begin
                        m_beats = 0;
                        m_last  = 1;
                    end
                end else begin
                    m_beats = 0;
                    m_last  = 1;
                end
            end else if (w >= 0) begin
                m_last = w;
                if (w == 1 && m1_lock) m_beats = 1;
            end
            if (w >= 0) begin
                if (b == 4'd0) begin
                    if (w == 0) begin e_rd0 = mm[a[9:2]]; e_rv0 = 1'b1; end
                    else        begin e_rd1 = mm[a[9:2]]; e_rv1 = 1'b1; end
                end else begin
                    mm[a[9:2]] = merge(mm[a[9:2]], d, b);
                end
            end
        end
        #1;
        chk("m0_rvalid", {31'd0, m0_rvalid}, {31'd0, e_rv0});
        chk("m1_rvalid", {31'd0, m1_rvalid}, {31'd0, e_rv1});
        chk("m0_rdata",  m0_rdata, e_rd0);
        chk("m1_rdata",  m1_rdata, e_rd1);
        @(negedge clock);
    endtask

    initial begin
        int k;
        for (int i = 0; i < 256; i++) begin
            ram[i] = $urandom;
            mm[i]  = ram[i];
        end
        ram[8'h40] = 32'hDEADBEEF; mm[8'h40] = 32'hDEADBEEF;  // 0x100
        ram[8'h08] = 32'hAABBCCDD; mm[8'h08] = 32'hAABBCCDD;  // 0x20
        m_last = 1; m_beats = 0; m_w = -1;
        e_rd0 = 32'd0; e_rd1 = 32'd0; e_rv0 = 1'b0; e_rv1 = 1'b0;

        reset = 1'b1;
        m0_req = 1'b1; m0_addr = 32'h100; m0_wdata = 32'h0; m0_wb = 4'd0;
        m1_req = 1'b1; m1_addr = 32'h104; m1_wdata = 32'h0; m1_wb = 4'd0;
        m1_lock = 1'b0;
        @(negedge clock);

        // Reset held two cycles with both requesting
        cycle();
        cycle();
        reset = 1'b0;

        // First cycle after release: m0 reads 0x100
        cycle();
        chk("first_winner_m0", {31'd0, m0_gnt}, 32'd0);
        chk("m0_read_0x100", m0_rdata, 32'hDEADBEEF);

        // Continuous contention without lock: alternation
        for (int i = 0; i < 6; i++) cycle();

        // Idle cycle: no grants, valid pulses end
        m0_req = 1'b0; m1_req = 1'b0;
        cycle();

        // m1 partial write to 0x20, then m0 reads it back
        m1_req = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h11223344; m1_wb = 4'b0011;
        cycle();
        m1_req = 1'b0; m1_wb = 4'd0;
        m0_req = 1'b1; m0_addr = 32'h20;
        cycle();
        chk("raw_merge_0x20", m0_rdata, 32'hAABB3344);
        m0_req = 1'b0;
        cycle();

        // Locked burst with both requesting
        m0_req = 1'b1; m0_addr = 32'h30;
        m1_req = 1'b1; m1_addr = 32'h34; m1_lock = 1'b1;
        for (int i = 0; i < 10; i++) cycle();

        // Reset in the middle of a burst
        k = 0;
        while (m_beats != 1 && k < 20) begin
            cycle();
            k++;
        end
        chk("burst_reached", m_beats, 32'd1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) cycle();

        // Random traffic with stable-until-granted requests
        pend0 = 1'b0; pend1 = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!pend0 && ($urandom % 3 != 0)) begin
                pend0    = 1'b1;
                m0_addr  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
                m0_wdata = $urandom;
                m0_wb    = ($urandom % 2 == 0) ? 4'd0 : 4'($urandom);
            end
            if (!pend1 && ($urandom % 3 != 0)) begin
                pend1    = 1'b1;
                m1_addr  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
                m1_wdata = $urandom;
                m1_wb    = ($urandom % 2 == 0) ? 4'd0 : 4'($urandom);
            end
            m0_req  = pend0;
            m1_req  = pend1;
            m1_lock = ($urandom % 4 != 0);
            reset   = ($urandom % 60 == 0);
            cycle();
            if (m_w == 0) pend0 = 1'b0;
            if (m_w == 1) pend1 = 1'b0;
        end
        reset = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter that shares one single-port RAM (byte-addressed, 32-bit word, 4-bit byte write strobes, combinational read) between a processor port (m0) and a DMA/network-interface port (m1). It sits between the requesters and the RAM's memory interface. It issues one access per cycle and registers read data back to the winning requester. Round-robin arbitration applies, plus a bounded locked-burst mode for m1.

## Interface
- MEMORY_BUS_WIDTH, 32, data width of every data bus
- ADDR_WIDTH, 32, byte address width
- MAX_BURST, 16, maximum consecutive m1 beats in a locked burst (≥2)

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- m0_req  in  1  m0 access request; addr/wdata/wb held stable until m0_gnt
- m0_addr  in  ADDR_WIDTH  m0 byte address
- m0_wdata  in  MEMORY_BUS_WIDTH  m0 write data
- m0_wb  in  4  m0 byte strobes, [3]=bits 31:24 at addr; 0000 = read
- m0_gnt  out  1  m0 access performed this cycle
- m0_rdata  out  MEMORY_BUS_WIDTH  registered m0 read data
- m0_rvalid  out  1  m0_rdata valid this cycle
- m1_req, m1_addr, m1_wdata, m1_wb, m1_gnt, m1_rdata, m1_rvalid: same as m0 for m1
- m1_lock  in  1  m1 requests a locked burst
- mem_enable_out  out  1  RAM enable
- mem_addr_out  out  ADDR_WIDTH  RAM byte address
- mem_data_out  out  MEMORY_BUS_WIDTH  RAM write data
- mem_wb_out  out  4  RAM byte strobes
- mem_data_in  in  MEMORY_BUS_WIDTH  RAM combinational read data

## Operation
- State: FSM {ARB, BURST}, last-winner pointer `last`, burst counter `cnt` (sized for MAX_BURST, saturating, never wraps).
- ARB:
  - Only one requester has req high: grant it.
  - Both have req high: grant the requester that is not `last`.
  - `last` updates to the winner on each grant.
  - If m1 is granted with m1_lock=1: go to BURST, set cnt=1.
- BURST:
  - m1_gnt = m1_req; m0_gnt = 0.
  - cnt increments on each granted beat.
  - Return to ARB when m1_req=0, m1_lock=0, or the MAX_BURST-th beat has been granted. The MAX_BURST-th beat is the last one granted.
  - On exit, set `last`=m1, so m0 wins the next contested cycle.
  - The cycle that exits on m1_lock=0 or m1_req=0 grants nothing to m1 in BURST. Arbitration resumes next cycle.
- Granted cycle:
  - mem_enable_out=1; mem_addr_out/mem_data_out/mem_wb_out driven from the winner.
  - Write when wb≠0, read when wb=0.
  - Addresses pass through unmodified; misalignment is not checked.
- No grant: mem_enable_out=0, mem_addr_out=0, mem_data_out=0, mem_wb_out=0.
- Read return:
  - On a granted read, the winner's rdata register captures mem_data_in at the clock edge.
  - The winner's rvalid is 1 in the following cycle only.
  - Writes never assert rvalid.
  - The loser's rdata holds its previous value; its rvalid is 0.
- Reset (synchronous, also mid-burst):
  - State ARB, `last`=m1, cnt=0.
  - m0_rdata=m1_rdata=0, m0_rvalid=m1_rvalid=0.
  - Any burst in progress is aborted.
  - m0_gnt, m1_gnt, mem_enable_out are forced to 0 while reset is high.

## Timing
- gnt and mem_* outputs are combinational from req/lock/state in the same cycle.
- The RAM write commits at the rising edge ending the granted cycle.
- Read latency: rdata/rvalid are valid 1 cycle after gnt.
- Throughput: one access per cycle, back-to-back reads allowed.
- An un-granted requester keeps req and fields stable; it sees gnt in a later cycle.
- Worst-case m0 wait while m1 bursts: MAX_BURST cycles.
- Read-after-write to the same address in the next cycle returns new data.

## Test plan
- Reset held 2 cycles with m0_req=m1_req=1 -> gnt=0, mem_enable_out=0, rvalid=0, rdata=0. First cycle after release grants m0.
- m0 reads 0x100, RAM holding 0xDEADBEEF -> m0_gnt=1, mem_addr_out=0x100, mem_wb_out=0000 same cycle. Next cycle m0_rvalid=1, m0_rdata=0xDEADBEEF. Then m0_rvalid=0.
- Both request continuously, m1_lock=0, for 6 cycles -> grants m0,m1,m0,m1,m0,m1. Exactly one gnt per cycle. Each read yields one rvalid pulse.
- MAX_BURST=4, m1_lock=1, both requesting -> m0 granted first, then m1 granted 4 consecutive cycles, then m0, then alternation resumes.
- m1 writes 0x11223344 with wb=0011 to 0x20 (RAM 0xAABBCCDD); m0 then reads 0x20 -> m1_rvalid stays 0; m0_rdata=0xAABB3344.
- Reset asserted at burst beat 2 for 1 cycle, both requesting after release -> m1_gnt=0 during reset. m0 wins the first contested cycle after release, then m1 (lock held) starts a new burst with cnt=1.
